// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - registered RV32I execute stage with iterative shifter and valid/ready output
module ex_stage_mc #(
    parameter int XLEN       = 32,
    parameter int REG_IDX_W  = 5,
    parameter int SHIFT_STEP = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 flush_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [3:0]           op_in,
    input  logic                 rdE_in,
    input  logic [REG_IDX_W-1:0] rdIdx_in,
    input  logic [XLEN-1:0]      rs1Data_in,
    input  logic [XLEN-1:0]      rs2Data_in,
    input  logic [XLEN-1:0]      pc_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 rdE_out,
    output logic [REG_IDX_W-1:0] rdIdx_out,
    output logic [XLEN-1:0]      rdData_out,
    output logic                 pcE_out,
    output logic [XLEN-1:0]      pcAddr_out,
    output logic                 busy_out
);
    localparam int SAW = $clog2(XLEN);
    localparam logic [SAW:0] STEP_MAX = (SAW+1)'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd2;
    localparam logic [3:0] OP_SLTU  = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_LUI   = 4'd7;
    localparam logic [3:0] OP_AUIPC = 4'd8;
    localparam logic [3:0] OP_SLL   = 4'd9;
    localparam logic [3:0] OP_SRL   = 4'd10;
    localparam logic [3:0] OP_SRA   = 4'd11;
    localparam logic [3:0] OP_JAL   = 4'd12;
    localparam logic [3:0] OP_JALR  = 4'd13;

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state_q, state_d;

    logic           out_free, accept, is_shift;
    logic [SAW-1:0] amt_in;

    assign out_free  = !valid_out || ready_in;
    assign ready_out = (state_q == IDLE) && out_free;
    assign accept    = valid_in && ready_out && !flush_in;
    assign amt_in    = rs2Data_in[SAW-1:0];
    assign is_shift  = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);
    assign busy_out  = (state_q == SHIFT);

    // single-cycle ALU; shift ops only reach the output from here when the amount is zero
    logic [XLEN-1:0] alu_data, alu_pca, sum_ab, pc_plus4;
    logic            alu_pce, alu_legal, alu_rde;

    always_comb begin
        sum_ab    = rs1Data_in + rs2Data_in;
        pc_plus4  = pc_in + XLEN'(4);
        alu_data  = '0;
        alu_pca   = '0;
        alu_pce   = 1'b0;
        alu_legal = 1'b1;
        case (op_in)
            OP_ADD:   alu_data = sum_ab;
            OP_SUB:   alu_data = rs1Data_in - rs2Data_in;
            OP_SLT:   alu_data = {{(XLEN-1){1'b0}}, ($signed(rs1Data_in) < $signed(rs2Data_in))};
            OP_SLTU:  alu_data = {{(XLEN-1){1'b0}}, (rs1Data_in < rs2Data_in)};
            OP_XOR:   alu_data = rs1Data_in ^ rs2Data_in;
            OP_OR:    alu_data = rs1Data_in | rs2Data_in;
            OP_AND:   alu_data = rs1Data_in & rs2Data_in;
            OP_LUI:   alu_data = rs2Data_in;
            OP_AUIPC: alu_data = pc_in + rs2Data_in;
            OP_SLL, OP_SRL, OP_SRA: alu_data = rs1Data_in;
            OP_JAL: begin
                alu_data = pc_plus4;
                alu_pce  = 1'b1;
                alu_pca  = pc_in + rs2Data_in;
            end
            OP_JALR: begin
                alu_data = pc_plus4;
                alu_pce  = 1'b1;
                alu_pca  = {sum_ab[XLEN-1:1], 1'b0};
            end
            default: alu_legal = 1'b0;
        endcase
        alu_rde = rdE_in && alu_legal && (rdIdx_in != '0);
    end

    // iterative shifter: sh_kind_q holds op[1:0] (1 SLL, 2 SRL, 3 SRA)
    logic [XLEN-1:0]      sh_val_q, sh_next;
    logic [SAW-1:0]       sh_rem_q, sh_step, sh_rem_next;
    logic [1:0]           sh_kind_q;
    logic                 sh_rde_q;
    logic [REG_IDX_W-1:0] sh_idx_q;

    always_comb begin
        sh_step = ({1'b0, sh_rem_q} > STEP_MAX) ? STEP_MAX[SAW-1:0] : sh_rem_q;
        case (sh_kind_q)
            2'd1:    sh_next = sh_val_q << sh_step;
            2'd2:    sh_next = sh_val_q >> sh_step;
            default: sh_next = $unsigned($signed(sh_val_q) >>> sh_step);
        endcase
        sh_rem_next = sh_rem_q - sh_step;
    end

    logic load_alu, load_sh, start_sh;

    always_comb begin
        state_d  = state_q;
        load_alu = 1'b0;
        load_sh  = 1'b0;
        start_sh = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (amt_in != '0)) begin
                        start_sh = 1'b1;
                        state_d  = SHIFT;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            SHIFT: begin
                // the final step lands directly in the output register when it is free
                if ((sh_rem_next == '0) && out_free) begin
                    load_sh = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_in) begin
            state_d  = IDLE;
            load_alu = 1'b0;
            load_sh  = 1'b0;
            start_sh = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            sh_val_q   <= '0;
            sh_rem_q   <= '0;
            sh_kind_q  <= '0;
            sh_rde_q   <= 1'b0;
            sh_idx_q   <= '0;
            valid_out  <= 1'b0;
            rdE_out    <= 1'b0;
            rdIdx_out  <= '0;
            rdData_out <= '0;
            pcE_out    <= 1'b0;
            pcAddr_out <= '0;
        end else begin
            state_q <= state_d;
            if (start_sh) begin
                sh_val_q  <= rs1Data_in;
                sh_rem_q  <= amt_in;
                sh_kind_q <= op_in[1:0];
                sh_rde_q  <= alu_rde;
                sh_idx_q  <= rdIdx_in;
            end else if (state_q == SHIFT) begin
                sh_val_q <= sh_next;
                sh_rem_q <= sh_rem_next;
            end

            if (flush_in) begin
                valid_out <= 1'b0;
                rdE_out   <= 1'b0;
                pcE_out   <= 1'b0;
            end else if (load_alu) begin
                valid_out  <= 1'b1;
                rdE_out    <= alu_rde;
                rdIdx_out  <= rdIdx_in;
                rdData_out <= alu_data;
                pcE_out    <= alu_pce;
                pcAddr_out <= alu_pca;
            end else if (load_sh) begin
                valid_out  <= 1'b1;
                rdE_out    <= sh_rde_q;
                rdIdx_out  <= sh_idx_q;
                rdData_out <= sh_next;
                pcE_out    <= 1'b0;
                pcAddr_out <= '0;
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
                pcE_out   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - scoreboard bench for ex_stage_mc with random stimulus and reference model
module tb_ex_stage_mc;
    logic        clk_in = 1'b0;
    logic        rst_in, flush_in, valid_in, ready_in, rdE_in;
    logic [3:0]  op_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rs1Data_in, rs2Data_in, pc_in;
    logic        ready_out, valid_out, rdE_out, pcE_out, busy_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out, pcAddr_out;

    logic        valid8, ready8, flush8;
    logic        ready8_o, valid8_o, rde8_o, pce8_o, busy8_o;
    logic [4:0]  idx8_o;
    logic [31:0] data8_o, pca8_o;

    always #5 clk_in = ~clk_in;

    ex_stage_mc #(.XLEN(32), .REG_IDX_W(5), .SHIFT_STEP(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .valid_in(valid_in),
        .ready_out(ready_out), .op_in(op_in), .rdE_in(rdE_in), .rdIdx_in(rdIdx_in),
        .rs1Data_in(rs1Data_in), .rs2Data_in(rs2Data_in), .pc_in(pc_in),
        .valid_out(valid_out), .ready_in(ready_in), .rdE_out(rdE_out),
        .rdIdx_out(rdIdx_out), .rdData_out(rdData_out), .pcE_out(pcE_out),
        .pcAddr_out(pcAddr_out), .busy_out(busy_out));

    ex_stage_mc #(.XLEN(32), .REG_IDX_W(5), .SHIFT_STEP(8)) dut8 (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush8), .valid_in(valid8),
        .ready_out(ready8_o), .op_in(op_in), .rdE_in(rdE_in), .rdIdx_in(rdIdx_in),
        .rs1Data_in(rs1Data_in), .rs2Data_in(rs2Data_in), .pc_in(pc_in),
        .valid_out(valid8_o), .ready_in(ready8), .rdE_out(rde8_o),
        .rdIdx_out(idx8_o), .rdData_out(data8_o), .pcE_out(pce8_o),
        .pcAddr_out(pca8_o), .busy_out(busy8_o));

    typedef struct packed {
        logic [31:0] data;
        logic        rde;
        logic [4:0]  idx;
        logic        pce;
        logic [31:0] pca;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    bit   rand_mode = 0;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic rde, input logic [4:0] idx);
        exp_t e;
        int   n;
        bit   legal;
        n = int'(b[4:0]);
        legal = 1;
        e = '0;
        e.idx = idx;
        case (op)
            4'd0:  e.data = a + b;
            4'd1:  e.data = a - b;
            4'd2:  e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  e.data = (a < b) ? 32'd1 : 32'd0;
            4'd4:  e.data = a ^ b;
            4'd5:  e.data = a | b;
            4'd6:  e.data = a & b;
            4'd7:  e.data = b;
            4'd8:  e.data = pc + b;
            4'd9:  e.data = a << n;
            4'd10: e.data = a >> n;
            4'd11: e.data = $unsigned($signed(a) >>> n);
            4'd12: begin e.data = pc + 32'd4; e.pce = 1; e.pca = pc + b; end
            4'd13: begin e.data = pc + 32'd4; e.pce = 1; e.pca = (a + b) & 32'hFFFF_FFFE; end
            default: begin e.data = 0; legal = 0; end
        endcase
        e.rde = rde && legal && (idx != 0);
        return e;
    endfunction

    // monitor: pushes on accept, pops on output handshake, flush/reset discard everything in flight
    initial begin
        exp_t        e;
        bit          held;
        logic [31:0] h_data;
        logic [7:0]  h_ctl;
        held = 0;
        @(negedge rst_in);
        forever begin
            @(negedge clk_in);
            if (held) begin
                chk("hold_data", rdData_out, h_data);
                chk("hold_ctl", {valid_out, rdE_out, pcE_out, rdIdx_out}, h_ctl);
            end
            if (!valid_out) chk("pce_when_invalid", pcE_out, 0);
            held   = valid_out && !ready_in && !flush_in && !rst_in;
            h_data = rdData_out;
            h_ctl  = {valid_out, rdE_out, pcE_out, rdIdx_out};
            if (rst_in || flush_in) begin
                sb_q.delete();
            end else begin
                if (valid_out && ready_in) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got data=%h exp=none at %0t", rdData_out, $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_data", rdData_out, e.data);
                        chk("out_rde", rdE_out, e.rde);
                        chk("out_idx", rdIdx_out, e.idx);
                        chk("out_pce", pcE_out, e.pce);
                        if (e.pce) chk("out_pca", pcAddr_out, e.pca);
                    end
                end
                if (valid_in && ready_out)
                    sb_q.push_back(model(op_in, rs1Data_in, rs2Data_in, pc_in, rdE_in, rdIdx_in));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (rand_mode) begin
            ready_in = ($urandom_range(0, 3) != 0);
            flush_in = ($urandom_range(0, 39) == 0);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic rde, input logic [4:0] idx);
        bit acc;
        acc = 0;
        op_in = op; rs1Data_in = a; rs2Data_in = b; pc_in = pc; rdE_in = rde; rdIdx_in = idx;
        valid_in = 1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk_in);
            acc = ready_out && !flush_in;
            tick();
        end
        valid_in = 0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout got=not_accepted exp=accepted op=%0d", op);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc, busy;
        logic [3:0] op;
        logic [31:0] a, b;
        exp_t e;
        rst_in = 1; flush_in = 0; valid_in = 0; ready_in = 1; rdE_in = 0; op_in = 0;
        rdIdx_in = 0; rs1Data_in = 0; rs2Data_in = 0; pc_in = 0;
        valid8 = 0; ready8 = 1; flush8 = 0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 0;
        chk("rst_valid", valid_out, 0);
        chk("rst_ctl", {rdE_out, pcE_out, busy_out}, 0);
        chk("rst_idx", rdIdx_out, 0);
        chk("rst_data", rdData_out, 0);
        chk("rst_pca", pcAddr_out, 0);
        chk("rst_ready", ready_out, 1);

        issue(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 5'd5);
        chk("add_valid", valid_out, 1);
        chk("add_data", rdData_out, 32'h0);
        issue(4'd1, 32'h0, 32'd1, 32'h0, 1, 5'd6);
        chk("sub_data", rdData_out, 32'hFFFF_FFFF);
        issue(4'd2, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 5'd7);
        chk("slt_data", rdData_out, 32'd1);
        issue(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 5'd8);
        chk("sltu_data", rdData_out, 32'd0);
        issue(4'd0, 32'd3, 32'd4, 32'h0, 1, 5'd0);
        chk("rd0_rde", rdE_out, 0);
        repeat (2) tick();

        issue(4'd11, 32'h8000_0000, 32'd31, 32'h0, 1, 5'd9);
        cyc = 0; busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            cyc++;
            if (busy_out && !ready_out) busy++;
            if (valid_out) break;
        end
        chk("sra_busy_cycles", busy, 31);
        chk("sra_latency", cyc, 32);
        chk("sra_data", rdData_out, 32'hFFFF_FFFF);
        tick();

        issue(4'd13, 32'h2001, 32'h10, 32'h100, 1, 5'd1);
        chk("jalr_data", rdData_out, 32'h104);
        chk("jalr_pce", pcE_out, 1);
        chk("jalr_pca", pcAddr_out, 32'h2010);
        issue(4'd8, 32'h0, 32'h1000, 32'h100, 1, 5'd2);
        chk("auipc_data", rdData_out, 32'h1100);
        chk("auipc_pce", pcE_out, 0);

        // backpressure with the AUIPC result held
        ready_in = 0;
        op_in = 4'd0; rs1Data_in = 32'h1234; rs2Data_in = 32'h1111; rdE_in = 1; rdIdx_in = 5'd3;
        valid_in = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("bp_ready_low", ready_out, 0);
            chk("bp_valid_held", valid_out, 1);
            tick();
        end
        ready_in = 1;
        @(negedge clk_in);
        chk("bp_ready_release", ready_out, 1);
        tick();
        valid_in = 0;
        chk("bp_no_bubble", valid_out, 1);
        chk("bp_data", rdData_out, 32'h2345);
        repeat (2) tick();

        // flush after 10 of 31 shift steps, with a concurrent offer
        issue(4'd9, 32'h1, 32'd31, 32'h0, 1, 5'd4);
        repeat (10) tick();
        chk("flush_busy_before", busy_out, 1);
        op_in = 4'd0; rs1Data_in = 32'd1; rs2Data_in = 32'd1; valid_in = 1; flush_in = 1;
        tick();
        flush_in = 0; valid_in = 0;
        chk("flush_busy", busy_out, 0);
        chk("flush_valid", valid_out, 0);
        repeat (3) tick();
        chk("flush_not_accepted", valid_out, 0);

        issue(4'd11, 32'hF000_0000, 32'd20, 32'h0, 1, 5'd4);
        repeat (5) tick();
        rst_in = 1;
        tick();
        rst_in = 0;
        chk("midrst_ctl", {valid_out, rdE_out, pcE_out, busy_out}, 0);
        chk("midrst_data", rdData_out, 0);
        chk("midrst_idx", rdIdx_out, 0);
        chk("midrst_pca", pcAddr_out, 0);

        rand_mode = 1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            op = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            issue(op, a, b, $urandom & 32'hFFFF_FFFC, 1'($urandom), 5'($urandom));
        end
        rand_mode = 0;
        ready_in = 1;
        flush_in = 0;
        repeat (60) tick();
        chk("sb_drained", sb_q.size(), 0);

        // SHIFT_STEP=8 instance
        for (int n = 0; n < 12; n++) begin
            if (n == 0) begin
                op = 4'd11; a = 32'h8000_0000; b = 32'd31;
            end else begin
                op = 4'($urandom_range(9, 11)); a = pick(); b = $urandom;
            end
            op_in = op; rs1Data_in = a; rs2Data_in = b; rdE_in = 1; rdIdx_in = 5'd12; pc_in = 0;
            e = model(op, a, b, 32'h0, 1, 5'd12);
            valid8 = 1;
            @(negedge clk_in);
            chk("s8_ready", ready8_o, 1);
            tick();
            valid8 = 0;
            cyc = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk_in);
                cyc++;
                if (valid8_o) break;
            end
            chk("s8_latency", cyc, (b[4:0] == 0) ? 1 : ((int'(b[4:0]) + 7) / 8) + 1);
            chk("s8_data", data8_o, e.data);
            chk("s8_rde", rde8_o, e.rde);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised, registered successor to the combinational execute stage of the RV32I pipeline.
- Sits between ID/EX and MEM.
- Executes the full integer ALU set: add/sub, compares, logic, LUI, AUIPC, JAL, JALR and shifts.
- Shifts run on an iterative multi-cycle shifter.
- Results are held in an output register with a valid/ready handshake. Flush aborts in-flight work.

Parameters:
- XLEN, 32, datapath width in bits; power of two, 32 or 64.
- REG_IDX_W, 5, register index width.
- SHIFT_STEP, 1, bits shifted per cycle; power of two, 1..XLEN.

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  reset; synchronous, active-high
- flush_in  input  1  pipeline flush; synchronous
- valid_in  input  1  upstream instruction valid
- ready_out  output  1  stage can accept an instruction this cycle
- op_in  input  4  operation code (table in Behaviour)
- rdE_in  input  1  destination write enable
- rdIdx_in  input  REG_IDX_W  destination register index
- rs1Data_in  input  XLEN  operand A
- rs2Data_in  input  XLEN  operand B (rs2 or immediate)
- pc_in  input  XLEN  instruction PC
- valid_out  output  1  result register valid
- ready_in  input  1  downstream accepts the result
- rdE_out  output  1  registered write enable
- rdIdx_out  output  REG_IDX_W  registered destination index
- rdData_out  output  XLEN  registered result
- pcE_out  output  1  redirect request, qualified by valid_out
- pcAddr_out  output  XLEN  redirect target
- busy_out  output  1  high while in SHIFT

Behaviour:
- op_in encoding and results (A = rs1Data_in, B = rs2Data_in):
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 SLT: signed A<B, result 1 or 0
  - 3 SLTU: unsigned A<B, result 1 or 0
  - 4 XOR, 5 OR, 6 AND: bitwise on A, B
  - 7 LUI: B
  - 8 AUIPC: pc_in+B
  - 9 SLL, 10 SRL, 11 SRA: shift A by B[log2(XLEN)-1:0]
  - 12 JAL: rd=pc_in+4; pcE=1; target pc_in+B
  - 13 JALR: rd=pc_in+4; pcE=1; target (A+B) with bit0 cleared
  - 14, 15 illegal: rdData 0, rdE forced 0, pcE 0
- All arithmetic is modulo 2^XLEN. AUIPC does not redirect the PC.
- When rdIdx_in==0, rdE_out is forced 0.
- Reset (rst_in high at an edge): state IDLE. valid_out, rdE_out, pcE_out and busy_out are 0. rdIdx_out, rdData_out and pcAddr_out are 0. Any shift in progress is discarded.
- States: IDLE, SHIFT.
- Accept condition: valid_in && ready_out && !flush_in.
- ready_out = (state==IDLE) && (!valid_out || ready_in). It is combinational and not dependent on valid_in.
- Non-shift op, or shift with amount 0, accepted at edge T: result register loaded at T, valid_out=1 from cycle T+1. Zero-bubble back-to-back issue is possible.
- Shift with amount n>0 accepted at edge T:
  - Enter SHIFT; latch A, op, rd fields and remaining=n.
  - Each cycle, shift by min(SHIFT_STEP, remaining). SRA fills with sign bits; SLL and SRL fill with zeros.
  - After k=ceil(n/SHIFT_STEP) steps, the result is ready. It is written to the output register on the first edge where (!valid_out || ready_in); then return to IDLE.
  - Unstalled, valid_out rises in cycle T+k+1.
- Output hold: while valid_out && !ready_in, all outputs hold stable.
- Output drain: valid_out drops after a handshake edge unless a new result loads on that same edge.
- Flush (flush_in high at an edge, rst_in low):
  - valid_out, rdE_out and pcE_out are cleared.
  - SHIFT aborts to IDLE.
  - Input offered on that edge is not accepted.
  - Flush takes priority over any simultaneous handshake or load.
  - Data fields may retain stale values.
- Reset has priority over flush.
- pcE_out is only meaningful when valid_out=1 and must be 0 whenever valid_out=0.

Test Plan:
- ADD A=0xFFFFFFFF, B=1 → one cycle later valid_out=1, rdData_out=0x00000000. SUB A=0, B=1 → 0xFFFFFFFF.
- SLT A=0xFFFFFFFF, B=1 → 1. SLTU with the same operands → 0. rdIdx_in=0 with rdE_in=1 → rdE_out=0.
- SRA A=0x80000000, B=31, SHIFT_STEP=1 → busy_out high and ready_out low for 31 cycles; valid_out rises at T+32 with rdData_out=0xFFFFFFFF. Repeat with SHIFT_STEP=8 → valid at T+5, same result.
- JALR pc=0x100, A=0x2001, B=0x10 → rdData_out=0x104, pcE_out=1, pcAddr_out=0x2010. AUIPC pc=0x100, B=0x1000 → 0x1100 with pcE_out=0.
- Backpressure: hold ready_in=0 for 5 cycles with a result held → outputs stable, ready_out=0. Release ready_in → the next ADD is accepted the same cycle and its result appears with no bubble.
- Flush at shift step 10 of 31 → next cycle IDLE, valid_out=0, busy_out=0. A concurrent valid_in is not accepted. Reset asserted mid-shift → all outputs 0 one cycle later.
